// File: rtl/vip_sobel_edge_detector_mm.sv
// Sobel edge detector for the gray (Y) video stream.
// Two line buffers plus a 3x3 window feed a 5-stage pipeline. The output is
// bypass Y, a binary edge map or saturated magnitude, chosen per frame.
// A per-frame count of edge pixels is also reported.
// Sync signals and data share one fixed 5-clk latency. The pipeline advances
// every clk, and clken only qualifies data.
module vip_sobel_edge_detector_mm #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int DW        = 8,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [DW-1:0]    per_img_Y,
  input  logic [DW+2:0]    Sobel_Threshold,
  input  logic [1:0]       Sobel_Mode,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic [DW-1:0]    post_img_Y,
  output logic [CNT_W-1:0] frame_edge_cnt,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int MW = DW + 3;
  localparam logic [CW-1:0]    L_HMAX = CW'(IMG_HDISP);
  localparam logic [RW-1:0]    L_VMAX = RW'(IMG_VDISP);
  localparam logic [CW-1:0]    L_TWO_C = CW'(2);
  localparam logic [RW-1:0]    L_TWO_R = RW'(2);
  localparam logic [MW-1:0]    L_YMAX = {3'b000, {DW{1'b1}}};
  localparam logic [CNT_W-1:0] L_CMAX = {CNT_W{1'b1}};

  // Edge detection and per-frame configuration
  logic             r_vs_prev, r_hs_prev;
  logic [1:0]       r_mode;
  logic [MW-1:0]    r_thr;
  // Position counters
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  // Sync delay lines, bit 4 is the output
  logic [4:0]       r_vs_d, r_hs_d, r_ce_d;
  // Line buffers: lb1 holds row r-1, lb2 holds row r-2
  logic [DW-1:0]    r_lb1 [0:IMG_HDISP-1];
  logic [DW-1:0]    r_lb2 [0:IMG_HDISP-1];
  // 3x3 window: first digit is the row (1 = r-2), second is the column (1 = c-2)
  logic [DW-1:0]    r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
  // Pipeline stages
  logic             r_s1_pix, r_s1_ok, r_s2_pix, r_s2_ok, r_s3_pix, r_s3_ok, r_s4_pix;
  logic [DW-1:0]    r_s1_y, r_s2_y, r_s3_y, r_s4_y;
  logic signed [MW-1:0] r_gx, r_gy;
  logic [MW-1:0]    r_ax, r_ay, r_mag;
  logic             r_out_bit;
  logic [DW-1:0]    r_out_y;
  // Edge counter
  logic             r_pvs_prev;
  logic [CNT_W-1:0] r_cnt, r_edge_cnt;
  logic             r_done;

  logic             w_vs_rise, w_hs_fall, w_pix, w_ok, w_edge, w_pvs_fall;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_lb1_q, w_lb2_q, w_out_y;
  logic [DW+1:0]    w_gxp, w_gxn, w_gyp, w_gyn;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_vs_rise = per_frame_vsync & ~r_vs_prev;
  assign w_hs_fall = ~per_frame_href & r_hs_prev;
  // Only in-range pixels are written to the line buffers and processed
  assign w_pix     = per_frame_clken & per_frame_href & (r_col < L_HMAX);
  assign w_ok      = w_pix & (r_row >= L_TWO_R) & (r_col >= L_TWO_C);
  assign w_addr    = r_col[AW-1:0];
  assign w_lb1_q   = r_lb1[w_addr];
  assign w_lb2_q   = r_lb2[w_addr];

  // Track previous sync levels and latch the mode/threshold at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_hs_prev <= 1'b0;
      r_mode    <= 2'b00;
      r_thr     <= '0;
    end else begin
      r_vs_prev <= per_frame_vsync;
      r_hs_prev <= per_frame_href;
      if (w_vs_rise) begin
        r_mode <= Sobel_Mode;
        r_thr  <= Sobel_Threshold;
      end
    end
  end

  // Column and row counters, both saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (w_hs_fall || w_vs_rise) r_col <= '0;
      else if (per_frame_clken && per_frame_href && r_col != L_HMAX) r_col <= r_col + 1'b1;
      if (w_vs_rise) r_row <= '0;
      else if (w_hs_fall && r_row != L_VMAX) r_row <= r_row + 1'b1;
    end
  end

  // Line buffers roll one row down on each in-range pixel. Contents need no reset.
  always_ff @(posedge clk) begin
    if (w_pix) begin
      r_lb2[w_addr] <= w_lb1_q;
      r_lb1[w_addr] <= per_img_Y;
    end
  end

  // Sync delay lines, 5 clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= '0;
      r_hs_d <= '0;
      r_ce_d <= '0;
    end else begin
      r_vs_d <= {r_vs_d[3:0], per_frame_vsync};
      r_hs_d <= {r_hs_d[3:0], per_frame_href};
      r_ce_d <= {r_ce_d[3:0], per_frame_clken};
    end
  end

  // S1: shift the window one column left on each processed pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33} <= '0;
      r_s1_pix <= 1'b0;
      r_s1_ok  <= 1'b0;
      r_s1_y   <= '0;
    end else begin
      if (w_pix) begin
        r_p11 <= r_p12; r_p12 <= r_p13; r_p13 <= w_lb2_q;
        r_p21 <= r_p22; r_p22 <= r_p23; r_p23 <= w_lb1_q;
        r_p31 <= r_p32; r_p32 <= r_p33; r_p33 <= per_img_Y;
      end
      r_s1_pix <= w_pix;
      r_s1_ok  <= w_ok;
      r_s1_y   <= per_img_Y;
    end
  end

  assign w_gxp = {2'b00, r_p13} + {1'b0, r_p23, 1'b0} + {2'b00, r_p33};
  assign w_gxn = {2'b00, r_p11} + {1'b0, r_p21, 1'b0} + {2'b00, r_p31};
  assign w_gyp = {2'b00, r_p31} + {1'b0, r_p32, 1'b0} + {2'b00, r_p33};
  assign w_gyn = {2'b00, r_p11} + {1'b0, r_p12, 1'b0} + {2'b00, r_p13};

  // S2..S4: signed gradients, absolute values, then magnitude masked by the border
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gx <= '0; r_gy <= '0; r_ax <= '0; r_ay <= '0; r_mag <= '0;
      r_s2_pix <= 1'b0; r_s2_ok <= 1'b0; r_s2_y <= '0;
      r_s3_pix <= 1'b0; r_s3_ok <= 1'b0; r_s3_y <= '0;
      r_s4_pix <= 1'b0; r_s4_y <= '0;
    end else begin
      r_gx     <= $signed({1'b0, w_gxp}) - $signed({1'b0, w_gxn});
      r_gy     <= $signed({1'b0, w_gyp}) - $signed({1'b0, w_gyn});
      r_s2_pix <= r_s1_pix; r_s2_ok <= r_s1_ok; r_s2_y <= r_s1_y;
      r_ax     <= r_gx[MW-1] ? -r_gx : r_gx;
      r_ay     <= r_gy[MW-1] ? -r_gy : r_gy;
      r_s3_pix <= r_s2_pix; r_s3_ok <= r_s2_ok; r_s3_y <= r_s2_y;
      r_mag    <= r_s3_ok ? (r_ax + r_ay) : '0;
      r_s4_pix <= r_s3_pix; r_s4_y <= r_s3_y;
    end
  end

  assign w_edge = r_s4_pix & (r_mag > r_thr);

  // S5 output mux selection; non-pixel slots produce 0
  always_comb begin
    w_out_y = '0;
    if (r_s4_pix) begin
      case (r_mode)
        2'b00:   w_out_y = r_s4_y;
        2'b10:   w_out_y = (r_mag > L_YMAX) ? {DW{1'b1}} : r_mag[DW-1:0];
        default: w_out_y = {DW{w_edge}};
      endcase
    end
  end

  // S5: register the output pixel and edge flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_y   <= '0;
      r_out_bit <= 1'b0;
    end else begin
      r_out_y   <= w_out_y;
      r_out_bit <= w_edge;
    end
  end

  assign w_pvs_fall = r_pvs_prev & ~r_vs_d[4];
  assign w_cnt_next = (r_ce_d[4] && r_out_bit && r_cnt != L_CMAX) ? r_cnt + 1'b1 : r_cnt;

  // Count output edges, and publish the count when the output frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pvs_prev <= 1'b0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_pvs_prev <= r_vs_d[4];
      if (w_pvs_fall) begin
        r_edge_cnt <= w_cnt_next;
        r_cnt      <= '0;
        r_done     <= 1'b1;
      end else begin
        r_cnt      <= w_cnt_next;
        r_done     <= 1'b0;
      end
    end
  end

  assign post_frame_vsync = r_vs_d[4];
  assign post_frame_href  = r_hs_d[4];
  assign post_frame_clken = r_ce_d[4];
  assign post_img_Bit     = r_out_bit;
  assign post_img_Y       = r_out_y;
  assign frame_edge_cnt   = r_edge_cnt;
  assign frame_done       = r_done;

endmodule

// File: tb/tb_vip_sobel_edge_detector_mm.sv
// Bench for vip_sobel_edge_detector_mm on a 16x8 image.
// Reference: each output is computed straight from the stored frame image
// with the Sobel kernels, then queued with its sync bits and compared 5 clk later.
module tb_vip_sobel_edge_detector_mm;
  localparam int HD = 16;
  localparam int VD = 8;
  localparam int DW = 8;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             per_frame_vsync, per_frame_href, per_frame_clken;
  logic [DW-1:0]    per_img_Y;
  logic [DW+2:0]    Sobel_Threshold;
  logic [1:0]       Sobel_Mode;
  logic             post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
  logic [DW-1:0]    post_img_Y;
  logic [CNT_W-1:0] frame_edge_cnt;
  logic             frame_done;

  int total = 0;
  int bad = 0;
  int step_idx = 0;
  int done_hits = 0;
  int done_step = 0;
  logic [11:0] exp_q[$];
  int img [0:VD-1][0:HD+1];

  vip_sobel_edge_detector_mm #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .DW(DW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Y(per_img_Y),
    .Sobel_Threshold(Sobel_Threshold), .Sobel_Mode(Sobel_Mode),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit),
    .post_img_Y(post_img_Y), .frame_edge_cnt(frame_edge_cnt), .frame_done(frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic prefill();
    exp_q.delete();
    repeat (4) exp_q.push_back(12'd0);
  endtask

  // Reference: result {bit, Y} for the pixel at (r, c) of the stored image
  function automatic logic [8:0] model(input int r, input int c, input logic [1:0] mode, input int thr);
    int gx, gy, mag;
    logic e;
    logic [7:0] yo;
    if (c >= HD) return 9'd0;
    mag = 0;
    if (r >= 2 && c >= 2) begin
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    end
    e = (mag > thr);
    case (mode)
      2'b00:   yo = 8'(img[r][c]);
      2'b10:   yo = (mag > 255) ? 8'd255 : 8'(mag);
      default: yo = e ? 8'd255 : 8'd0;
    endcase
    return {e, yo};
  endfunction

  // Drive one clock of input, then check the output belonging to 5 clk earlier
  task automatic step(input logic vs, input logic hs, input logic ce, input logic [7:0] y, input logic [8:0] res);
    logic [11:0] e;
    per_frame_vsync = vs;
    per_frame_href  = hs;
    per_frame_clken = ce;
    per_img_Y       = y;
    @(posedge clk);
    #1;
    step_idx++;
    exp_q.push_back({vs, hs, ce, res});
    if (frame_done === 1'b1) begin
      done_hits++;
      done_step = step_idx;
    end
    if (exp_q.size() >= 5) begin
      e = exp_q.pop_front();
      chk("pipe_out", {20'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, post_img_Y}, {20'd0, e});
    end
  endtask

  // One frame: mode/thr are the values seen at vsync rise; mid_* are applied right after
  task automatic run_frame(input logic [1:0] mode, input int thr, input int max_extra, input int gap_pct,
                           input logic [1:0] mid_mode, input int mid_thr, input int rst_row, output int cnt);
    int len, fall_step;
    logic [8:0] res;
    cnt = 0;
    done_hits = 0;
    Sobel_Mode = mode;
    Sobel_Threshold = 11'(thr);
    repeat (2) step(0, 0, 0, 8'd0, 9'd0);
    repeat (3) step(1, 0, 0, 8'd0, 9'd0);
    Sobel_Mode = mid_mode;
    Sobel_Threshold = 11'(mid_thr);
    for (int r = 0; r < VD; r++) begin
      if (r == rst_row) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {26'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, post_img_Y, frame_done}, 32'd0);
        chk("async_rst_cnt", 32'(frame_edge_cnt), 32'd0);
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prefill();
        repeat (8) step(0, 0, 0, 8'd0, 9'd0);
        chk("post_rst_cnt", 32'(frame_edge_cnt), 32'd0);
        return;
      end
      len = HD + $urandom_range(0, max_extra);
      for (int c = 0; c < len; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
          step(1, 1, 0, 8'($urandom_range(0, 255)), 9'd0);
        res = model(r, c, mode, thr);
        if (res[8]) cnt++;
        step(1, 1, 1, 8'(img[r][c]), res);
      end
      repeat (3) step(1, 0, 0, 8'd0, 9'd0);
    end
    fall_step = step_idx + 1;
    repeat (10) step(0, 0, 0, 8'd0, 9'd0);
    chk("done_count", 32'(done_hits), 32'd1);
    chk("done_time", 32'(done_step), 32'(fall_step + 5));
    chk("edge_cnt_model", 32'(frame_edge_cnt), 32'(cnt));
  endtask

  task automatic fill_flat(input int v);
    for (int r = 0; r < VD; r++) for (int c = 0; c < HD + 2; c++) img[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < VD; r++) for (int c = 0; c < HD + 2; c++) img[r][c] = (c < 8) ? 0 : 200;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < VD; r++) for (int c = 0; c < HD + 2; c++) img[r][c] = $urandom_range(0, 255);
  endtask

  initial begin
    int cnt;
    logic [1:0] m;
    int t;
    // Reset
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_Y = '0; Sobel_Threshold = '0; Sobel_Mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {26'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, post_img_Y, frame_done}, 32'd0);
    chk("reset_cnt", 32'(frame_edge_cnt), 32'd0);
    rst_n = 1'b1;
    prefill();
    repeat (4) step(0, 0, 0, 8'd0, 9'd0);

    // Flat frame: no gradient anywhere
    fill_flat(100);
    run_frame(2'b10, 0, 0, 0, 2'b10, 0, -1, cnt);
    chk("flat_cnt", 32'(frame_edge_cnt), 32'd0);

    // Vertical step in magnitude mode
    fill_step();
    run_frame(2'b10, 2047, 0, 0, 2'b10, 2047, -1, cnt);
    chk("step_mag_cnt", 32'(frame_edge_cnt), 32'd0);

    // Threshold boundary: 799 passes 800, 800 does not
    run_frame(2'b01, 799, 0, 0, 2'b01, 799, -1, cnt);
    chk("step_thr799_cnt", 32'(frame_edge_cnt), 32'd12);
    run_frame(2'b01, 800, 0, 0, 2'b01, 800, -1, cnt);
    chk("step_thr800_cnt", 32'(frame_edge_cnt), 32'd0);
    run_frame(2'b01, 100, 0, 0, 2'b01, 100, -1, cnt);
    chk("step_thr100_cnt", 32'(frame_edge_cnt), 32'd12);
    run_frame(2'b11, 100, 0, 0, 2'b11, 100, -1, cnt);
    chk("step_mode11_cnt", 32'(frame_edge_cnt), 32'd12);

    // Mid-frame config change is ignored until the next frame
    fill_rand();
    run_frame(2'b10, 300, 2, 10, 2'b00, 5, -1, cnt);
    run_frame(2'b00, 5, 2, 10, 2'b00, 5, -1, cnt);

    // Reset during a frame, then a clean frame
    fill_rand();
    run_frame(2'b01, 400, 0, 0, 2'b01, 400, 4, cnt);
    run_frame(2'b01, 400, 0, 0, 2'b01, 400, -1, cnt);

    // Random frames, overlong lines and clken gaps
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      m = 2'($urandom_range(0, 3));
      t = $urandom_range(0, 2047);
      run_frame(m, t, 2, 20, m, t, -1, cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
